cpu_run_ctrl: RTL and testbench

- Synthesizable run controller for one or more CPU cores. Successor to the fixed bench clock/reset stimulus.
- Stretches reset to each core for a parametrised number of cycles, then starts the cores automatically or on command.
- Counts run cycles and detects completion: all cores halted, or a watchdog timeout.
- Sits between the top-level clk/rst and the core instances (TOP_CPU or its successors), usable in benches and on FPGA.

---
 rtl/cpu_run_pkg.sv | 17 +
 rtl/rst_stretch.sv | 62 ++++++
 rtl/cpu_run_ctrl.sv | 226 ++++++++++++++++++++++
 tb/tb_cpu_run_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_run_pkg.sv
// cpu_run_pkg: shared types and defaults for the CPU run controller.
//   run_state_e      - controller state encoding (HOLD, IDLE, RUN, DONE)
//   DEF_RST_CYCLES   - default reset-stretch length in cycles
//   DEF_TIMEOUT      - default watchdog limit in run cycles (0 disables)
package cpu_run_pkg;

    typedef enum logic [1:0] {
        HOLD = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } run_state_e;

    localparam int DEF_RST_CYCLES = 4;
    localparam int DEF_TIMEOUT    = 10000;

endpackage

// File: rtl/rst_stretch.sv
// rst_stretch: hold counter plus registered reset generation.
// The counter runs 0..RST_CYCLES-1 while cnt_en is high and wraps to 0 after
// the last count, so the next stretch always starts from zero. rst_out is the
// registered copy of rst_nxt fanned out to WIDTH bits; it is all 1s in reset.
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   cnt_en    in   advance the hold counter this cycle
//   cnt_clr   in   force the hold counter back to 0
//   rst_nxt   in   reset level to present on rst_out after this edge
//   cnt_last  out  hold counter is at RST_CYCLES-1 (combinational)
//   rst_out   out  registered reset, WIDTH bits, active-high
module rst_stretch #(
    parameter int WIDTH      = 1,
    parameter int RST_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cnt_en,
    input  logic             cnt_clr,
    input  logic             rst_nxt,
    output logic             cnt_last,
    output logic [WIDTH-1:0] rst_out
);

    localparam int              HC_W    = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [HC_W-1:0] HC_LAST = HC_W'(RST_CYCLES - 1);
    localparam logic [HC_W-1:0] HC_ONE  = HC_W'(1);

    logic [HC_W-1:0] hold_cnt_r;
    logic [HC_W-1:0] hold_cnt_nxt_s;

    assign cnt_last = (hold_cnt_r == HC_LAST);

    // Next hold count: clear wins, otherwise count and wrap on the last value.
    always_comb begin
        hold_cnt_nxt_s = hold_cnt_r;
        if (cnt_clr) begin
            hold_cnt_nxt_s = {HC_W{1'b0}};
        end else if (cnt_en) begin
            if (cnt_last) begin
                hold_cnt_nxt_s = {HC_W{1'b0}};
            end else begin
                hold_cnt_nxt_s = hold_cnt_r + HC_ONE;
            end
        end else begin
            hold_cnt_nxt_s = hold_cnt_r;
        end
    end

    // Hold counter and registered reset outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt_r <= {HC_W{1'b0}};
            rst_out    <= {WIDTH{1'b1}};
        end else begin
            hold_cnt_r <= hold_cnt_nxt_s;
            rst_out    <= {WIDTH{rst_nxt}};
        end
    end

endmodule

// File: rtl/cpu_run_ctrl.sv
// cpu_run_ctrl: run controller for N_CORES CPU cores.
// Stretches reset to the cores, starts them automatically or on a start pulse,
// counts run cycles and ends the run when every core has been seen halted or
// when the watchdog expires. All outputs are registered.
// Optional feature (macro RUN_CTRL_DUMP_EN): on entry to DONE, walk dump_addr
// 0..DUMP_DEPTH-1 with dump_valid high, one address per cycle.
// Ports:
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset, overrides everything
//   start        in   pulse: leave IDLE, or restart from DONE
//   core_halt    in   per-core halt level, only looked at in RUN
//   core_rst     out  per-core active-high reset
//   running      out  high in RUN
//   done         out  high in DONE
//   timeout      out  run ended by the watchdog (valid in DONE)
//   halted_mask  out  sticky record of cores seen halted this run
//   cycle_count  out  run cycles elapsed, saturating
//   dump_valid   out  (RUN_CTRL_DUMP_EN only) dump address valid
//   dump_addr    out  (RUN_CTRL_DUMP_EN only) current dump address
module cpu_run_ctrl
    import cpu_run_pkg::*;
#(
    parameter int N_CORES    = 1,
    parameter int RST_CYCLES = DEF_RST_CYCLES,
    parameter int CNT_W      = 32,
    parameter int TIMEOUT    = DEF_TIMEOUT,
    parameter int AUTO_START = 1,
    parameter int DUMP_DEPTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N_CORES-1:0] core_halt,
    output logic [N_CORES-1:0] core_rst,
    output logic               running,
    output logic               done,
    output logic               timeout,
    output logic [N_CORES-1:0] halted_mask,
    output logic [CNT_W-1:0]   cycle_count
`ifdef RUN_CTRL_DUMP_EN
    ,
    output logic                          dump_valid,
    output logic [$clog2(DUMP_DEPTH)-1:0] dump_addr
`endif
);

    // Parameter sanity checks, resolved at elaboration.
    if (N_CORES < 1 || N_CORES > 8) begin : g_bad_cores
        $error("cpu_run_ctrl: N_CORES must be in 1..8");
    end
    if (RST_CYCLES < 1) begin : g_bad_rst_cycles
        $error("cpu_run_ctrl: RST_CYCLES must be at least 1");
    end
    if (DUMP_DEPTH < 2 || (DUMP_DEPTH & (DUMP_DEPTH - 1)) != 0) begin : g_bad_dump_depth
        $error("cpu_run_ctrl: DUMP_DEPTH must be a power of two, at least 2");
    end

    // The watchdog compares the incremented count one bit wider than the
    // counter, so a limit of exactly 2**CNT_W is still reachable. Limits that
    // cannot be represented at all simply never fire.
    localparam logic             WDOG_EN  = (TIMEOUT > 0) && ($clog2(TIMEOUT + 1) <= CNT_W + 1);
    localparam logic [CNT_W:0]   WDOG_LIM = (CNT_W + 1)'(TIMEOUT);
    localparam logic [CNT_W:0]   CNT_ONE  = (CNT_W + 1)'(1);

    run_state_e          state_r;
    run_state_e          state_nxt_s;
    logic                running_r;
    logic                done_r;
    logic                timeout_r;
    logic                timeout_nxt_s;
    logic [N_CORES-1:0]  mask_r;
    logic [N_CORES-1:0]  mask_nxt_s;
    logic [CNT_W-1:0]    count_r;
    logic [CNT_W-1:0]    count_nxt_s;
    logic [CNT_W:0]      cnt_inc_s;
    logic [CNT_W-1:0]    cnt_sat_s;
    logic                wdog_hit_s;
    logic                hold_en_s;
    logic                hold_clr_s;
    logic                hold_last_s;

    assign cnt_inc_s  = {1'b0, count_r} + CNT_ONE;
    assign cnt_sat_s  = (&count_r) ? count_r : cnt_inc_s[CNT_W-1:0];
    assign wdog_hit_s = WDOG_EN && (cnt_inc_s == WDOG_LIM);

    // Next-state and next-register logic for the run FSM.
    always_comb begin
        state_nxt_s   = state_r;
        count_nxt_s   = count_r;
        mask_nxt_s    = mask_r;
        timeout_nxt_s = timeout_r;
        hold_en_s     = 1'b0;
        hold_clr_s    = 1'b0;
        case (state_r)
            HOLD: begin
                hold_en_s = 1'b1;
                if (hold_last_s) begin
                    state_nxt_s = (AUTO_START != 0) ? RUN : IDLE;
                end else begin
                    state_nxt_s = HOLD;
                end
            end
            IDLE: begin
                if (start) begin
                    state_nxt_s = RUN;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            RUN: begin
                count_nxt_s = cnt_sat_s;
                mask_nxt_s  = mask_r | core_halt;
                // All-halted is tested first so it wins over a same-edge timeout.
                if (&mask_nxt_s) begin
                    state_nxt_s   = DONE;
                    timeout_nxt_s = 1'b0;
                end else if (wdog_hit_s) begin
                    state_nxt_s   = DONE;
                    timeout_nxt_s = 1'b1;
                end else begin
                    state_nxt_s = RUN;
                end
            end
            DONE: begin
                if (start) begin
                    state_nxt_s   = HOLD;
                    count_nxt_s   = {CNT_W{1'b0}};
                    mask_nxt_s    = {N_CORES{1'b0}};
                    timeout_nxt_s = 1'b0;
                    hold_clr_s    = 1'b1;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s   = HOLD;
                count_nxt_s   = {CNT_W{1'b0}};
                mask_nxt_s    = {N_CORES{1'b0}};
                timeout_nxt_s = 1'b0;
                hold_clr_s    = 1'b1;
            end
        endcase
    end

    // FSM state, counters and status outputs, all registered from next values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= HOLD;
            running_r <= 1'b0;
            done_r    <= 1'b0;
            timeout_r <= 1'b0;
            mask_r    <= {N_CORES{1'b0}};
            count_r   <= {CNT_W{1'b0}};
        end else begin
            state_r   <= state_nxt_s;
            running_r <= (state_nxt_s == RUN);
            done_r    <= (state_nxt_s == DONE);
            timeout_r <= timeout_nxt_s;
            mask_r    <= mask_nxt_s;
            count_r   <= count_nxt_s;
        end
    end

    // Cores are held in reset in every state except RUN.
    rst_stretch #(
        .WIDTH      (N_CORES),
        .RST_CYCLES (RST_CYCLES)
    ) u_rst_stretch (
        .clk      (clk),
        .rst      (rst),
        .cnt_en   (hold_en_s),
        .cnt_clr  (hold_clr_s),
        .rst_nxt  (state_nxt_s != RUN),
        .cnt_last (hold_last_s),
        .rst_out  (core_rst)
    );

    assign running     = running_r;
    assign done        = done_r;
    assign timeout     = timeout_r;
    assign halted_mask = mask_r;
    assign cycle_count = count_r;

`ifdef RUN_CTRL_DUMP_EN
    localparam int              DA_W    = $clog2(DUMP_DEPTH);
    localparam logic [DA_W-1:0] DA_LAST = DA_W'(DUMP_DEPTH - 1);
    localparam logic [DA_W-1:0] DA_ONE  = DA_W'(1);

    logic            dump_valid_r;
    logic            dump_valid_nxt_s;
    logic [DA_W-1:0] dump_addr_r;
    logic [DA_W-1:0] dump_addr_nxt_s;

    // Dump walker: start at 0 on entry to DONE, step while DONE is held,
    // drop out after the last address or as soon as DONE is left.
    always_comb begin
        dump_valid_nxt_s = 1'b0;
        dump_addr_nxt_s  = {DA_W{1'b0}};
        if (state_r == RUN && state_nxt_s == DONE) begin
            dump_valid_nxt_s = 1'b1;
            dump_addr_nxt_s  = {DA_W{1'b0}};
        end else if (dump_valid_r && state_nxt_s == DONE && dump_addr_r != DA_LAST) begin
            dump_valid_nxt_s = 1'b1;
            dump_addr_nxt_s  = dump_addr_r + DA_ONE;
        end else begin
            dump_valid_nxt_s = 1'b0;
            dump_addr_nxt_s  = {DA_W{1'b0}};
        end
    end

    // Dump walker registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            dump_valid_r <= 1'b0;
            dump_addr_r  <= {DA_W{1'b0}};
        end else begin
            dump_valid_r <= dump_valid_nxt_s;
            dump_addr_r  <= dump_addr_nxt_s;
        end
    end

    assign dump_valid = dump_valid_r;
    assign dump_addr  = dump_addr_r;
`endif

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl.
// u_a: 2 cores, RST_CYCLES=4, TIMEOUT=50, AUTO_START=1.
// u_b: 1 core, RST_CYCLES=2, CNT_W=4, TIMEOUT=0, AUTO_START=0.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_cpu_run_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, start_a = 1'b0;
    logic [1:0]  halt_a = 2'b00;
    logic [1:0]  core_rst_a, halted_mask_a;
    logic        running_a, done_a, timeout_a;
    logic [31:0] cycle_count_a;

    logic        rst_b = 1'b1, start_b = 1'b0;
    logic [0:0]  halt_b = 1'b0;
    logic [0:0]  core_rst_b, halted_mask_b;
    logic        running_b, done_b, timeout_b;
    logic [3:0]  cycle_count_b;
`ifdef RUN_CTRL_DUMP_EN
    logic        dump_valid_a, dump_valid_b;
    logic [4:0]  dump_addr_a, dump_addr_b;
`endif

    cpu_run_ctrl #(
        .N_CORES(2), .RST_CYCLES(4), .CNT_W(32), .TIMEOUT(50), .AUTO_START(1)
    ) u_a (
        .clk(clk), .rst(rst_a), .start(start_a), .core_halt(halt_a),
        .core_rst(core_rst_a), .running(running_a), .done(done_a),
        .timeout(timeout_a), .halted_mask(halted_mask_a), .cycle_count(cycle_count_a)
`ifdef RUN_CTRL_DUMP_EN
        , .dump_valid(dump_valid_a), .dump_addr(dump_addr_a)
`endif
    );

    cpu_run_ctrl #(
        .N_CORES(1), .RST_CYCLES(2), .CNT_W(4), .TIMEOUT(0), .AUTO_START(0)
    ) u_b (
        .clk(clk), .rst(rst_b), .start(start_b), .core_halt(halt_b),
        .core_rst(core_rst_b), .running(running_b), .done(done_b),
        .timeout(timeout_b), .halted_mask(halted_mask_b), .cycle_count(cycle_count_b)
`ifdef RUN_CTRL_DUMP_EN
        , .dump_valid(dump_valid_b), .dump_addr(dump_addr_b)
`endif
    );

    typedef struct packed {
        logic        done;
        logic        timeout;
        logic        running;
        logic [1:0]  core_rst;
        logic [1:0]  mask;
        logic [31:0] count;
        logic [7:0]  lat;
    } res_t;

    res_t exp_q[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    function automatic res_t snap_a(input int lat);
        res_t r;
        r.done     = done_a;
        r.timeout  = timeout_a;
        r.running  = running_a;
        r.core_rst = core_rst_a;
        r.mask     = halted_mask_a;
        r.count    = cycle_count_a;
        r.lat      = 8'(lat);
        return r;
    endfunction

    // Bounded wait for done on u_a; lat = falling edges waited.
    task automatic wait_done_a(input int budget, output int lat);
        lat = 0;
        while (done_a !== 1'b1 && lat < budget) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // Start pulse from DONE, then bounded wait for running on u_a.
    task automatic restart_a(output int lat);
        halt_a  = 2'b00;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        lat = 0;
        while (running_a !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        logic [3:0] hist;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({done_a, timeout_a, running_a, core_rst_a, halted_mask_a, cycle_count_a} !==
            {1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 32'd0})
            $display("FAIL reset_values: got %b/%b/%b/%b/%b/%0d want 0/0/0/11/00/0",
                     done_a, timeout_a, running_a, core_rst_a, halted_mask_a, cycle_count_a);
        else pass_cnt++;
        rst_a = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            hist[4-k] = core_rst_a[0];
        end
        total_cnt++;
        if (hist !== 4'b1110)
            $display("FAIL reset_stretch: core_rst trace got %b want 1110", hist);
        else pass_cnt++;
        total_cnt++;
        if ({running_a, core_rst_a, cycle_count_a} !== {1'b1, 2'b00, 32'd0})
            $display("FAIL first_run_cycle: got run=%b rst=%b cnt=%0d want 1/00/0",
                     running_a, core_rst_a, cycle_count_a);
        else pass_cnt++;
    endtask

    task automatic test_multi_halt;
        res_t e, o;
        int   lat;
        exp_q.push_back('{done: 1'b1, timeout: 1'b0, running: 1'b0, core_rst: 2'b11,
                          mask: 2'b11, count: 32'd25, lat: 8'd0});
        for (int n = 1; n <= 25; n++) begin
            halt_a = (n == 10) ? 2'b01 : ((n == 25) ? 2'b10 : 2'b00);
            @(negedge clk);
            if (n == 10 || n == 20) begin
                total_cnt++;
                if ({done_a, halted_mask_a, cycle_count_a} !== {1'b0, 2'b01, 32'(n)})
                    $display("FAIL sticky_mask@%0d: got done=%b mask=%b cnt=%0d want 0/01/%0d",
                             n, done_a, halted_mask_a, cycle_count_a, n);
                else pass_cnt++;
            end
        end
        halt_a = 2'b00;
        wait_done_a(100, lat);
        o = snap_a(lat);
        e = exp_q.pop_front();
        total_cnt++;
        if (o !== e) $display("FAIL multi_halt: got %h want %h", o, e);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({done_a, halted_mask_a, cycle_count_a} !== {1'b1, 2'b11, 32'd25})
            $display("FAIL done_hold: got done=%b mask=%b cnt=%0d want 1/11/25",
                     done_a, halted_mask_a, cycle_count_a);
        else pass_cnt++;
    endtask

    task automatic test_restart;
        logic [3:0] hist;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        total_cnt++;
        if ({done_a, timeout_a, running_a, core_rst_a, halted_mask_a, cycle_count_a} !==
            {1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 32'd0})
            $display("FAIL restart_clear: got %b/%b/%b/%b/%b/%0d want 0/0/0/11/00/0",
                     done_a, timeout_a, running_a, core_rst_a, halted_mask_a, cycle_count_a);
        else pass_cnt++;
        start_a = 1'b1;            // must be ignored in HOLD
        @(negedge clk);
        start_a = 1'b0;
        hist[3] = core_rst_a[0];
        for (int k = 2; k >= 0; k--) begin
            @(negedge clk);
            hist[k] = core_rst_a[0];
        end
        total_cnt++;
        if (hist !== 4'b1110 || running_a !== 1'b1)
            $display("FAIL restart_stretch: trace got %b run=%b want 1110 run=1", hist, running_a);
        else pass_cnt++;
    endtask

    task automatic test_watchdog;
        res_t e, o;
        int   lat;
        exp_q.push_back('{done: 1'b1, timeout: 1'b1, running: 1'b0, core_rst: 2'b11,
                          mask: 2'b00, count: 32'd50, lat: 8'd45});
        repeat (4) @(negedge clk);
        start_a = 1'b1;            // must be ignored in RUN
        @(negedge clk);
        start_a = 1'b0;
        wait_done_a(200, lat);
        o = snap_a(lat);
        e = exp_q.pop_front();
        total_cnt++;
        if (o !== e) $display("FAIL watchdog: got %h want %h", o, e);
        else pass_cnt++;
    endtask

    task automatic test_halt_at_timeout;
        res_t e, o;
        int   lat;
        restart_a(lat);
        total_cnt++;
        if (lat !== 4) $display("FAIL restart_latency: got %0d want 4", lat);
        else pass_cnt++;
        repeat (49) @(negedge clk);
        total_cnt++;
        if ({running_a, cycle_count_a} !== {1'b1, 32'd49})
            $display("FAIL pre_timeout: got run=%b cnt=%0d want 1/49", running_a, cycle_count_a);
        else pass_cnt++;
        exp_q.push_back('{done: 1'b1, timeout: 1'b0, running: 1'b0, core_rst: 2'b11,
                          mask: 2'b11, count: 32'd50, lat: 8'd0});
        halt_a = 2'b11;
        @(negedge clk);
        halt_a = 2'b00;
        o = snap_a(0);
        e = exp_q.pop_front();
        total_cnt++;
        if (o !== e) $display("FAIL halt_at_timeout: got %h want %h", o, e);
        else pass_cnt++;
    endtask

    task automatic test_rst_mid_run;
        logic [3:0] hist;
        int lat;
        restart_a(lat);
        halt_a = 2'b01;
        repeat (10) @(negedge clk);
        halt_a = 2'b00;
        rst_a  = 1'b1;
        @(negedge clk);
        rst_a  = 1'b0;
        total_cnt++;
        if ({done_a, timeout_a, running_a, core_rst_a, halted_mask_a, cycle_count_a} !==
            {1'b0, 1'b0, 1'b0, 2'b11, 2'b00, 32'd0})
            $display("FAIL rst_mid_run: got %b/%b/%b/%b/%b/%0d want 0/0/0/11/00/0",
                     done_a, timeout_a, running_a, core_rst_a, halted_mask_a, cycle_count_a);
        else pass_cnt++;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            hist[4-k] = core_rst_a[0];
        end
        total_cnt++;
        if (hist !== 4'b1110)
            $display("FAIL rst_mid_run_stretch: trace got %b want 1110", hist);
        else pass_cnt++;
    endtask

`ifdef RUN_CTRL_DUMP_EN
    task automatic test_dump;
        int lat;
        halt_a = 2'b11;
        @(negedge clk);
        halt_a = 2'b00;
        for (int i = 0; i < 32; i++) begin
            total_cnt++;
            if ({dump_valid_a, dump_addr_a} !== {1'b1, 5'(i)})
                $display("FAIL dump_walk@%0d: got v=%b a=%0d want 1/%0d", i, dump_valid_a, dump_addr_a, i);
            else pass_cnt++;
            @(negedge clk);
        end
        total_cnt++;
        if ({dump_valid_a, dump_addr_a} !== {1'b0, 5'd0})
            $display("FAIL dump_end: got v=%b a=%0d want 0/0", dump_valid_a, dump_addr_a);
        else pass_cnt++;
        restart_a(lat);
        halt_a = 2'b11;
        @(negedge clk);
        halt_a = 2'b00;
        repeat (5) @(negedge clk);
        total_cnt++;
        if ({dump_valid_a, dump_addr_a} !== {1'b1, 5'd5})
            $display("FAIL dump_at5: got v=%b a=%0d want 1/5", dump_valid_a, dump_addr_a);
        else pass_cnt++;
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        total_cnt++;
        if ({dump_valid_a, dump_addr_a, done_a} !== {1'b0, 5'd0, 1'b0})
            $display("FAIL dump_abort: got v=%b a=%0d done=%b want 0/0/0", dump_valid_a, dump_addr_a, done_a);
        else pass_cnt++;
    endtask
`endif

    task automatic test_idle_start;
        int bad = 0;
        rst_b = 1'b0;
        repeat (100) begin
            @(negedge clk);
            if (core_rst_b !== 1'b1 || running_b !== 1'b0 || done_b !== 1'b0) bad++;
        end
        total_cnt++;
        if (bad !== 0) $display("FAIL idle_wait: got %0d bad cycles want 0", bad);
        else pass_cnt++;
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        total_cnt++;
        if ({running_b, core_rst_b, cycle_count_b} !== {1'b1, 1'b0, 4'd0})
            $display("FAIL idle_start: got run=%b rst=%b cnt=%0d want 1/0/0", running_b, core_rst_b, cycle_count_b);
        else pass_cnt++;
        repeat (20) @(negedge clk);
        total_cnt++;
        if ({running_b, done_b, timeout_b, cycle_count_b} !== {1'b1, 1'b0, 1'b0, 4'hF})
            $display("FAIL saturate: got run=%b done=%b to=%b cnt=%0d want 1/0/0/15",
                     running_b, done_b, timeout_b, cycle_count_b);
        else pass_cnt++;
        halt_b = 1'b1;
        @(negedge clk);
        halt_b = 1'b0;
        total_cnt++;
        if ({done_b, timeout_b, core_rst_b, cycle_count_b} !== {1'b1, 1'b0, 1'b1, 4'hF})
            $display("FAIL sat_halt: got done=%b to=%b rst=%b cnt=%0d want 1/0/1/15",
                     done_b, timeout_b, core_rst_b, cycle_count_b);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_multi_halt();
        test_restart();
        test_watchdog();
        test_halt_at_timeout();
        test_rst_mid_run();
`ifdef RUN_CTRL_DUMP_EN
        test_dump();
`endif
        test_idle_start();
        total_cnt++;
        if (exp_q.size() !== 0) $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
